hms_timekeeper: RTL and testbench
=================================

Name: hms_timekeeper

Overview:
- Parametrised time-of-day core that replaces the standalone hour counting with a single-clock cascade of seconds, minutes and hours.
- Built-in prescaler derives the one-per-second advance from clk.
- Adds a set-time handshake with range checking, manual minute/hour adjust, a 12h display mode and a day-rollover pulse.
- Feeds the display/BCD path and the alarm comparator.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per second; legal range 1..2^32-1; 1 = advance every cycle.
- HOURS_PER_DAY, 24, hour modulus; legal range 2..32.
- RESET_HOUR, 0, hour value loaded on reset; must be < HOURS_PER_DAY.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_all  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = time frozen.
- set_valid  in  1  load request.
- set_ready  out  1  load can be accepted this cycle.
- set_hour  in  5  value to load.
- set_min  in  6  value to load.
- set_sec  in  6  value to load.
- set_err  out  1  one-cycle pulse: load rejected.
- adj_hour_inc  in  1  one-cycle request: hour +1.
- adj_min_inc  in  1  one-cycle request: minute +1.
- mode_12h  in  1  display format select.
- hour  out  5  binary hour, 0..HOURS_PER_DAY-1.
- min  out  6  binary minute, 0..59.
- sec  out  6  binary second, 0..59.
- hour_disp  out  5  display hour.
- pm  out  1  PM flag.
- sec_tick  out  1  one-cycle pulse on every second advance.
- day_carry  out  1  one-cycle pulse on day wrap.

Behaviour:
- Reset (reset_all=1 at edge): hour=RESET_HOUR, min=0, sec=0, prescaler=0, set_ready=1, set_err=0, sec_tick=0, day_carry=0. Reset overrides every other input.
- Prescaler: counts 0..TICK_DIV-1 while run=1. Internal tick asserts when count==TICK_DIV-1 and run=1; count then wraps to 0. run=0 holds the count and produces no ticks.
- Priority per edge: reset > accepted set > adjust > tick.
- A tick that coincides with an accepted set or an adjust is discarded; sec_tick stays 0 that cycle.
- Tick: sec+1. At 59, sec->0 and min+1. At min 59, min->0 and hour+1. At hour HOURS_PER_DAY-1, hour->0.
- sec_tick=1 and day_carry=1 for the cycle following the advancing edge; both registered outputs.
- Set handshake: a load is accepted when set_valid=1 and set_ready=1 at the edge.
  - Range check: set_hour < HOURS_PER_DAY, set_min < 60, set_sec < 60.
  - Legal: hour/min/sec load on that edge, prescaler clears to 0, set_ready=0 for exactly the next cycle, then returns to 1.
  - Illegal: time and prescaler are unchanged, set_err=1 for one cycle, set_ready stays 1.
  - set_valid while set_ready=0 is ignored; no error.
- Adjust:
  - adj_min_inc: min+1 mod 60; no carry into hour; sec unchanged.
  - adj_hour_inc: hour+1 mod HOURS_PER_DAY; no day_carry.
  - Both asserted: both apply in the same edge.
  - Adjust does not touch the prescaler.
  - Adjust during an accepted set is ignored.
- Display: combinational from the hour register.
  - mode_12h=0 or HOURS_PER_DAY != 24: hour_disp=hour, pm=0.
  - mode_12h=1 with HOURS_PER_DAY=24: hour 0 -> 12, pm=0; hour 1..11 -> same, pm=0; hour 12 -> 12, pm=1; hour 13..23 -> hour-12, pm=1.
- All arithmetic is unsigned at the field width. No out-of-range value is ever reachable after reset.

Decomposition:
- Package hms_pkg: SEC_W=6, MIN_W=6, HOUR_W=5, MAX_SEC=59, MAX_MIN=59, and a to_12h function returning {pm, hour_disp}.
- Sub-module mod_counter (parameters MOD, W), instanced three times for sec, min and hour.
  - Inputs: clk, reset_all, rst_val, inc, load, load_val.
  - Outputs: value, wrap (combinational: inc && value==MOD-1).
  - The prescaler is a fourth instance with MOD=TICK_DIV.

Test Plan (TICK_DIV=4, HOURS_PER_DAY=24):
1. Reset, then run=1 -> time 00:00:00, set_ready=1; sec=1 after 4 cycles; sec_tick pulses once per 4 cycles; run=0 freezes time.
2. Load 23:59:58, run -> 23:59:59 after 4 cycles, then 00:00:00 with day_carry=1 for one cycle only.
3. Load 24:10:10 -> set_err=1 for one cycle; time unchanged; set_ready stays 1. Load 10:60:00 -> same result.
4. At 05:59:30, pulse adj_min_inc -> 05:00:30 with no hour change. At 23:xx, pulse adj_hour_inc -> hour 0 and day_carry=0.
5. mode_12h=1: hour 0 -> disp 12, pm 0; hour 12 -> 12, pm 1; hour 13 -> 1, pm 1; hour 23 -> 11, pm 1.
6. Priority checks:
   - set_valid coinciding with a tick, loading 08:00:00 -> reads 08:00:00, no advance, set_ready low for one cycle.
   - reset_all=1 with set_valid=1 -> 00:00:00, no load, no set_err.

Source files
------------

// File: rtl/hms_timekeeper_pkg.sv
// Shared field widths, limits and the 24h -> 12h display conversion for the
// hms_timekeeper time-of-day core.
package hms_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;

  // Set-handshake controller state, also exported for observation.
  typedef enum logic {
    ST_READY = 1'b0,
    ST_BUSY  = 1'b1
  } set_state_e;

  // Returns {pm, hour_disp}: midnight and noon both show as 12.
  function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] h24);
    logic                 pm_f;
    logic [HOUR_W-1:0]    h12;
    pm_f = (h24 >= 5'd12);
    h12  = pm_f ? (h24 - 5'd12) : h24;
    if (h12 == '0) begin
      h12 = 5'd12;
    end
    return {pm_f, h12};
  endfunction

endpackage

// File: rtl/hms_timekeeper_if.sv
// Set-time load channel: requester drives valid and the time fields, the
// timekeeper answers with ready and a one-cycle reject pulse.
interface hms_timekeeper_if;
  import hms_pkg::*;

  // Handshake: a load transfers on a rising clk edge where set_valid=1 and
  // set_ready=1; set_valid while set_ready=0 is dropped without an error,
  // and set_err pulses for one cycle when a transferred load is out of range.
  logic              set_valid;
  logic              set_ready;
  logic [HOUR_W-1:0] set_hour;
  logic [MIN_W-1:0]  set_min;
  logic [SEC_W-1:0]  set_sec;
  logic              set_err;

  modport master (
    output set_valid,
    output set_hour,
    output set_min,
    output set_sec,
    input  set_ready,
    input  set_err
  );

  modport slave (
    input  set_valid,
    input  set_hour,
    input  set_min,
    input  set_sec,
    output set_ready,
    output set_err
  );

endinterface

// File: rtl/hms_timekeeper_mod_counter.sv
// Modulo-MOD up-counter with synchronous reset value and parallel load;
// wrap flags the increment that returns the count to zero.
module mod_counter #(
  parameter longint unsigned MOD = 60,
  parameter int              W   = 6
) (
  input  logic         clk,
  input  logic         reset_all,
  input  logic [W-1:0] rst_val,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_value;

  assign value = r_value;
  assign wrap  = inc && (r_value == LAST);

  always_ff @(posedge clk) begin
    if (reset_all) begin
      r_value <= rst_val;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc) begin
      r_value <= wrap ? '0 : (r_value + W'(1));
    end
  end

endmodule

// File: rtl/hms_timekeeper.sv
// Time-of-day core: prescaler plus seconds/minutes/hours cascade, with a
// range-checked set handshake, manual adjust and a 12h display view.
module hms_timekeeper
  import hms_pkg::*;
#(
  parameter longint unsigned TICK_DIV      = 50_000_000,
  parameter int              HOURS_PER_DAY = 24,
  parameter int              RESET_HOUR    = 0
) (
  input  logic                 clk,
  input  logic                 reset_all,
  input  logic                 run,
  hms_timekeeper_if.slave      set_if,
  input  logic                 adj_hour_inc,
  input  logic                 adj_min_inc,
  input  logic                 mode_12h,
  output logic [HOUR_W-1:0]    hour,
  output logic [MIN_W-1:0]     min,
  output logic [SEC_W-1:0]     sec,
  output logic [HOUR_W-1:0]    hour_disp,
  output logic                 pm,
  output logic                 sec_tick,
  output logic                 day_carry,
  output set_state_e           dbg_state,
  output logic [((TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV))-1:0] dbg_prescale
);

  localparam int PRE_W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

  set_state_e        r_state;
  logic              r_set_ready;
  logic              r_set_err;
  logic              r_sec_tick;
  logic              r_day_carry;

  logic              w_set_acc;
  logic              w_in_range;
  logic              w_set_ok;
  logic              w_set_bad;
  logic              w_adj_hour;
  logic              w_adj_min;
  logic              w_pre_inc;
  logic              w_tick;
  logic              w_adv;
  logic              w_sec_wrap;
  logic              w_min_wrap;
  logic              w_hour_wrap;
  logic              w_min_inc;
  logic              w_hour_inc;
  logic [PRE_W-1:0]  w_pre;
  logic [HOUR_W-1:0] w_hour;
  logic [MIN_W-1:0]  w_min;
  logic [SEC_W-1:0]  w_sec;
  logic [HOUR_W:0]   w_disp;

  assign w_in_range = ({1'b0, set_if.set_hour} < 6'(HOURS_PER_DAY)) &&
                      (set_if.set_min <= MAX_MIN) &&
                      (set_if.set_sec <= MAX_SEC);

  // Any transferred request, legal or not, owns the edge: it freezes the
  // prescaler and masks adjust and tick for that cycle.
  assign w_set_acc = set_if.set_valid && r_set_ready;
  assign w_set_ok  = w_set_acc && w_in_range;
  assign w_set_bad = w_set_acc && !w_in_range;

  assign w_adj_hour = adj_hour_inc && !w_set_acc;
  assign w_adj_min  = adj_min_inc && !w_set_acc;

  assign w_pre_inc = run && !w_set_acc;
  assign w_adv     = w_tick && !(adj_hour_inc || adj_min_inc);

  // An adjusted minute wrap never carries: only a real second advance does.
  assign w_min_inc  = (w_adv && w_sec_wrap) || w_adj_min;
  assign w_hour_inc = (w_adv && w_min_wrap) || w_adj_hour;

  mod_counter #(.MOD(TICK_DIV), .W(PRE_W)) u_prescale (
    .clk      (clk),
    .reset_all(reset_all),
    .rst_val  ('0),
    .inc      (w_pre_inc),
    .load     (w_set_ok),
    .load_val ('0),
    .value    (w_pre),
    .wrap     (w_tick)
  );

  mod_counter #(.MOD(60), .W(SEC_W)) u_sec (
    .clk      (clk),
    .reset_all(reset_all),
    .rst_val  ('0),
    .inc      (w_adv),
    .load     (w_set_ok),
    .load_val (set_if.set_sec),
    .value    (w_sec),
    .wrap     (w_sec_wrap)
  );

  mod_counter #(.MOD(60), .W(MIN_W)) u_min (
    .clk      (clk),
    .reset_all(reset_all),
    .rst_val  ('0),
    .inc      (w_min_inc),
    .load     (w_set_ok),
    .load_val (set_if.set_min),
    .value    (w_min),
    .wrap     (w_min_wrap)
  );

  mod_counter #(.MOD(HOURS_PER_DAY), .W(HOUR_W)) u_hour (
    .clk      (clk),
    .reset_all(reset_all),
    .rst_val  (HOUR_W'(RESET_HOUR)),
    .inc      (w_hour_inc),
    .load     (w_set_ok),
    .load_val (set_if.set_hour),
    .value    (w_hour),
    .wrap     (w_hour_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset_all) begin
      r_state     <= ST_READY;
      r_set_ready <= 1'b1;
      r_set_err   <= 1'b0;
      r_sec_tick  <= 1'b0;
      r_day_carry <= 1'b0;
    end else begin
      r_set_err   <= w_set_bad;
      r_sec_tick  <= w_adv;
      r_day_carry <= w_adv && w_hour_wrap;
      case (r_state)
        ST_READY: begin
          if (w_set_ok) begin
            r_state     <= ST_BUSY;
            r_set_ready <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_state     <= ST_READY;
          r_set_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_READY;
          r_set_ready <= 1'b1;
        end
      endcase
    end
  end

  // The 12h view only makes sense for a 24-hour day.
  always_comb begin
    w_disp = {1'b0, w_hour};
    if (mode_12h && (HOURS_PER_DAY == 24)) begin
      w_disp = to_12h(w_hour);
    end
  end

  assign set_if.set_ready = r_set_ready;
  assign set_if.set_err   = r_set_err;

  assign hour         = w_hour;
  assign min          = w_min;
  assign sec          = w_sec;
  assign hour_disp    = w_disp[HOUR_W-1:0];
  assign pm           = w_disp[HOUR_W];
  assign sec_tick     = r_sec_tick;
  assign day_carry    = r_day_carry;
  assign dbg_state    = r_state;
  assign dbg_prescale = w_pre;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Bench for hms_timekeeper with TICK_DIV=4: directed sequences, a vector
// table for set/adjust/display/priority cases, then randomized traffic.
module tb_hms_timekeeper;
  import hms_pkg::*;

  localparam int TB_DIV  = 4;
  localparam int TB_HPD  = 24;
  localparam int OBS_W   = 27;
  localparam int N_RAND  = 4000;

  typedef struct {
    bit rst, run, sv;
    int sh, sm, ss;
    bit ah, am, md;
    logic [OBS_W-1:0] exp;
  } vec_t;

  logic              clk;
  logic              reset_all;
  logic              run;
  logic              adj_hour_inc;
  logic              adj_min_inc;
  logic              mode_12h;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  min;
  logic [SEC_W-1:0]  sec;
  logic [HOUR_W-1:0] hour_disp;
  logic              pm;
  logic              sec_tick;
  logic              day_carry;
  set_state_e        dbg_state;
  logic [1:0]        dbg_prescale;

  hms_timekeeper_if set_if();

  hms_timekeeper #(.TICK_DIV(TB_DIV), .HOURS_PER_DAY(TB_HPD), .RESET_HOUR(0)) dut (
    .clk         (clk),
    .reset_all   (reset_all),
    .run         (run),
    .set_if      (set_if),
    .adj_hour_inc(adj_hour_inc),
    .adj_min_inc (adj_min_inc),
    .mode_12h    (mode_12h),
    .hour        (hour),
    .min         (min),
    .sec         (sec),
    .hour_disp   (hour_disp),
    .pm          (pm),
    .sec_tick    (sec_tick),
    .day_carry   (day_carry),
    .dbg_state   (dbg_state),
    .dbg_prescale(dbg_prescale)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [OBS_W-1:0] exp_q[$];
  vec_t tbl[$];

  // ---------------- reference model (time as seconds-of-day) ----------------
  int m_tod, m_pre;
  bit m_rdy, m_err, m_tick, m_dc;

  function automatic logic [OBS_W-1:0] mk_obs(int h, int m, int s, bit rdy, bit err,
                                              bit tk, bit dc, int disp, bit pmf);
    return {5'(h), 6'(m), 6'(s), rdy, err, tk, dc, 5'(disp), pmf};
  endfunction

  function automatic vec_t mk_vec(bit rst, bit rn, bit sv, int sh, int sm, int ss,
                                  bit ah, bit am, bit md, int h, int m, int s,
                                  bit rdy, bit err, bit tk, bit dc, int disp, bit pmf);
    vec_t v;
    v.rst = rst; v.run = rn; v.sv = sv; v.sh = sh; v.sm = sm; v.ss = ss;
    v.ah = ah; v.am = am; v.md = md;
    v.exp = mk_obs(h, m, s, rdy, err, tk, dc, disp, pmf);
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit rn, input bit sv, input int sh,
                            input int sm, input int ss, input bit ah, input bit am);
    int h, m, s;
    bit acc, ok, tick;
    if (rst) begin
      m_tod = 0; m_pre = 0; m_rdy = 1; m_err = 0; m_tick = 0; m_dc = 0;
      return;
    end
    acc = sv && m_rdy;
    ok  = (sh < TB_HPD) && (sm < 60) && (ss < 60);
    m_err = acc && !ok; m_tick = 0; m_dc = 0;
    if (acc) begin
      if (ok) begin
        m_tod = sh * 3600 + sm * 60 + ss;
        m_pre = 0;
      end
    end else begin
      tick = rn && (m_pre == TB_DIV - 1);
      if (rn) m_pre = (m_pre + 1) % TB_DIV;
      h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
      if (ah || am) begin
        if (am) m = (m + 1) % 60;
        if (ah) h = (h + 1) % TB_HPD;
        m_tod = h * 3600 + m * 60 + s;
      end else if (tick) begin
        m_tod  = (m_tod + 1) % (TB_HPD * 3600);
        m_tick = 1;
        m_dc   = (m_tod == 0);
      end
    end
    m_rdy = !(acc && ok);
  endtask

  function automatic logic [OBS_W-1:0] model_obs(bit md);
    int h, disp;
    bit pmf;
    h = m_tod / 3600;
    disp = h; pmf = 0;
    if (md) begin
      pmf  = (h >= 12);
      disp = (h % 12 == 0) ? 12 : h % 12;
    end
    return mk_obs(h, (m_tod / 60) % 60, m_tod % 60, m_rdy, m_err, m_tick, m_dc, disp, pmf);
  endfunction

  // ---------------- driver / checker ----------------
  task automatic drive(input bit rst, input bit rn, input bit sv, input int sh,
                       input int sm, input int ss, input bit ah, input bit am, input bit md);
    reset_all        = rst;
    run              = rn;
    set_if.set_valid = sv;
    set_if.set_hour  = 5'(sh);
    set_if.set_min   = 6'(sm);
    set_if.set_sec   = 6'(ss);
    adj_hour_inc     = ah;
    adj_min_inc      = am;
    mode_12h         = md;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OBS_W-1:0] get_obs();
    return {hour, min, sec, set_if.set_ready, set_if.set_err, sec_tick, day_carry, hour_disp, pm};
  endfunction

  task automatic check(input string name, input logic [OBS_W-1:0] exp);
    logic [OBS_W-1:0] act;
    act = get_obs();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got h=%0d m=%0d s=%0d rdy=%b err=%b tk=%b dc=%b disp=%0d pm=%b, expected %h (got %h)",
               name, $time, hour, min, sec, set_if.set_ready, set_if.set_err, sec_tick,
               day_carry, hour_disp, pm, exp, act);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h, m, s, dsp;
    bit rst, rn, sv, ah, am, md;
    int sh, sm, ss;

    reset_all = 1'b1; run = 1'b0; adj_hour_inc = 1'b0; adj_min_inc = 1'b0; mode_12h = 1'b0;
    set_if.set_valid = 1'b0; set_if.set_hour = '0; set_if.set_min = '0; set_if.set_sec = '0;

    // Reset, then one second every 4 cycles, then frozen.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset", mk_obs(0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 12; c++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("run_tick", mk_obs(0, 0, c / 4, 1, 0, (c % 4 == 0), 0, 0, 0));
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("freeze", mk_obs(0, 0, 3, 1, 0, 0, 0, 0, 0));
    end

    // Day rollover from 23:59:58.
    drive(0, 1, 1, 23, 59, 58, 0, 0, 0);
    check("load_2359", mk_obs(23, 59, 58, 0, 0, 0, 0, 23, 0));
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      if (k < 4)      begin h = 23; m = 59; s = 58; end
      else if (k < 8) begin h = 23; m = 59; s = 59; end
      else            begin h = 0;  m = 0;  s = 0;  end
      check("rollover", mk_obs(h, m, s, 1, 0, (k == 4 || k == 8), (k == 8), h, 0));
    end

    // Vector table: rst run sv sh sm ss ah am md | h m s rdy err tk dc disp pm
    tbl.push_back(mk_vec(0,0,1,24,10,10,0,0,0,  0, 0, 0,1,1,0,0, 0,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,0,  0, 0, 0,1,0,0,0, 0,0));
    tbl.push_back(mk_vec(0,0,1,10,60, 0,0,0,0,  0, 0, 0,1,1,0,0, 0,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,0,  0, 0, 0,1,0,0,0, 0,0));
    tbl.push_back(mk_vec(0,0,1, 5,59,30,0,0,0,  5,59,30,0,0,0,0, 5,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,1,0,  5, 0,30,1,0,0,0, 5,0));
    tbl.push_back(mk_vec(0,0,1,23,15, 0,0,0,0, 23,15, 0,0,0,0,0,23,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,1,0,0,  0,15, 0,1,0,0,0, 0,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,1,1,0,  1,16, 0,1,0,0,0, 1,0));
    tbl.push_back(mk_vec(0,0,1,12, 0, 0,0,0,0, 12, 0, 0,0,0,0,0,12,0));
    tbl.push_back(mk_vec(0,0,1, 3, 3, 3,0,0,0, 12, 0, 0,1,0,0,0,12,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,1, 12, 0, 0,1,0,0,0,12,1));
    tbl.push_back(mk_vec(0,0,1,13, 0, 0,0,0,1, 13, 0, 0,0,0,0,0, 1,1));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,1, 13, 0, 0,1,0,0,0, 1,1));
    tbl.push_back(mk_vec(0,0,1,23, 0, 0,0,0,1, 23, 0, 0,0,0,0,0,11,1));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,1, 23, 0, 0,1,0,0,0,11,1));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,1,0,1,  0, 0, 0,1,0,0,0,12,0));
    tbl.push_back(mk_vec(0,0,1,11,30, 0,0,0,1, 11,30, 0,0,0,0,0,11,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,0,0, 11,30, 0,1,0,0,0,11,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,0,0, 11,30, 0,1,0,0,0,11,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,0,0, 11,30, 0,1,0,0,0,11,0));
    tbl.push_back(mk_vec(0,1,1, 8, 0, 0,0,0,0,  8, 0, 0,0,0,0,0, 8,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,0,0,  8, 0, 0,1,0,0,0, 8,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,0,0,  8, 0, 0,1,0,0,0, 8,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,0,0,  8, 0, 0,1,0,0,0, 8,0));
    tbl.push_back(mk_vec(0,1,0, 0, 0, 0,0,1,0,  8, 1, 0,1,0,0,0, 8,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,0,  8, 1, 0,1,0,0,0, 8,0));
    tbl.push_back(mk_vec(1,0,1, 8, 8, 8,0,0,0,  0, 0, 0,1,0,0,0, 0,0));
    tbl.push_back(mk_vec(0,0,0, 0, 0, 0,0,0,0,  0, 0, 0,1,0,0,0, 0,0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].run, tbl[i].sv, tbl[i].sh, tbl[i].sm, tbl[i].ss,
            tbl[i].ah, tbl[i].am, tbl[i].md);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Randomized traffic against the seconds-of-day model.
    for (int i = 0; i < N_RAND; i++) begin
      rst = (i == 0) || ($urandom_range(0, 299) == 0);
      rn  = ($urandom_range(0, 9) < 8);
      sv  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) begin
        sh = ($urandom_range(0, 1) == 1) ? 23 : $urandom_range(0, 23);
        sm = 59;
        ss = $urandom_range(56, 59);
      end else begin
        sh = $urandom_range(0, 26);
        sm = $urandom_range(0, 62);
        ss = $urandom_range(0, 62);
      end
      ah = ($urandom_range(0, 19) == 0);
      am = ($urandom_range(0, 19) == 0);
      md = $urandom_range(0, 1);
      model_step(rst, rn, sv, sh, sm, ss, ah, am);
      exp_q.push_back(model_obs(md));
      drive(rst, rn, sv, sh, sm, ss, ah, am, md);
      check("random", exp_q.pop_front());
    end

    dsp = n_fail;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, dsp);
    $finish;
  end

endmodule
